// File: rtl/seq_divider.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit per cycle.
// Optional two's-complement mode is compiled in with SEQ_DIVIDER_SIGNED_EN.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sgn,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW:0]   rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] div_q, div_d;
  logic [DW-1:0] quotient_q, quotient_d;
  logic [VW-1:0] remainder_q, remainder_d;
  logic          dz_q, dz_d;

  logic [VW:0]   shifted, diff, step_rem;
  logic          take;
  logic [DW-1:0] step_quo, q_fix;
  logic [VW-1:0] r_fix;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;
`endif

  // The top remainder bit is always 0 between iterations (rem < divisor).
  logic unused_bits;
  assign unused_bits = rem_q[VW] ^ sgn;

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    negq_d = negq_q;
    negr_d = negr_q;
    if (sgn) begin
      if (dividend[DW-1]) dvd_mag = -dividend;
      if (divisor[VW-1])  dvs_mag = -divisor;
    end
`endif

    shifted  = {rem_q[VW-1:0], quo_q[DW-1]};
    diff     = shifted - {1'b0, div_q};
    take     = (shifted >= {1'b0, div_q});
    step_rem = take ? diff : shifted;
    step_quo = {quo_q[DW-2:0], take};

    q_fix = step_quo;
    r_fix = step_rem[VW-1:0];
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (negq_q) q_fix = -step_quo;
    if (negr_q) r_fix = -step_rem[VW-1:0];
`endif

    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dz_d        = dz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          rem_d = '0;
          quo_d = dvd_mag;
          div_d = dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
          negq_d = sgn & (dividend[DW-1] ^ divisor[VW-1]);
          negr_d = sgn & dividend[DW-1];
`endif
          if (divisor != '0) begin
            state_d = CALC;
          end else begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend[VW-1:0];
            dz_d        = 1'b1;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          quotient_d  = q_fix;
          remainder_d = r_fix;
          dz_d        = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dz_q        <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q      <= negq_d;
      negr_q      <= negr_d;
`endif
    end
  end

  assign busy      = (state_q == CALC) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (default DW=16, VW=8); signed cases when SEQ_DIVIDER_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int DW = 16;
  localparam int VW = 8;
  localparam int PERIOD = 18;

  logic          clk;
  logic          reset;
  logic          start;
  logic          sgn;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dz;

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          z;
  } exp_t;

  exp_t exp_q[$];
  int   done_times[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b);
    exp_t e;
    int   sa, sb;
    if (b == '0) begin
      e.q = '1;
      e.r = a[VW-1:0];
      e.z = 1'b1;
      return e;
    end
    e.z = 1'b0;
    sa  = int'(a);
    sb  = int'(b);
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end
`endif
    e.q = DW'(sa / sb);
    e.r = VW'(sa % sb);
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (reset && done) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient",  32'(quotient),  32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("dz",        32'(dz),        32'(e.z));
        check("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  // Issue one division, push its expected result, and check done latency in edges.
  task automatic run_div(input string tag, input logic s, input logic [DW-1:0] a, input logic [VW-1:0] b);
    int n;
    int lat;
    int exp_lat;
    @(negedge clk);
    sgn      = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(model(s, a, b));
    exp_lat = (b == '0) ? 1 : DW + 1;
    @(posedge clk);
    #1 start = 1'b0;
    n   = 0;
    lat = 40;
    while (n < 40) begin
      @(negedge clk);
      if (done) begin
        lat = n + 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  initial begin
    int base;
    int n;
    start    = 1'b0;
    sgn      = 1'b0;
    dividend = '0;
    divisor  = '0;
    reset    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_quotient",  32'(quotient),  32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dz",        32'(dz),        32'd0);
    reset = 1'b1;

    run_div("d1000_7", 1'b0, 16'd1000, 8'd7);
    run_div("d1234_0", 1'b0, 16'd1234, 8'd0);
    run_div("dffff_ff", 1'b0, 16'hFFFF, 8'hFF);
    run_div("dffff_1",  1'b0, 16'hFFFF, 8'd1);
    run_div("d0_5",     1'b0, 16'd0,    8'd5);
    run_div("d255_255", 1'b0, 16'd255,  8'd255);
`ifndef SEQ_DIVIDER_SIGNED_EN
    run_div("sgn_ignored", 1'b1, 16'hFF9C, 8'd7);
`endif
    for (int i = 0; i < 8; i++) begin
      run_div("rand", 1'(i), 16'($urandom), 8'($urandom_range(1, 255)));
    end

    // Small dividend, with a start pulse injected during CALC that must be ignored.
    base = done_cnt;
    @(negedge clk);
    sgn = 1'b0; dividend = 16'd5; divisor = 8'd9; start = 1'b1;
    exp_q.push_back(model(1'b0, 16'd5, 8'd9));
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    dividend = 16'd100; divisor = 8'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("ignored_start_done_count", 32'(done_cnt - base), 32'd1);

    // Reset asserted mid-CALC aborts without a result.
    base = done_cnt;
    @(negedge clk);
    dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_quotient",  32'(quotient),  32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dz",        32'(dz),        32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (25) @(posedge clk);
    @(negedge clk);
    check("abort_no_done", 32'(done_cnt - base), 32'd0);
    run_div("d200_10", 1'b0, 16'd200, 8'd10);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_div("s_m100_7",   1'b1, 16'hFF9C, 8'd7);
    run_div("s_min_m1",   1'b1, 16'h8000, 8'hFF);
    run_div("s_100_m7",   1'b1, 16'd100,  8'hF9);
    run_div("s_m100_m7",  1'b1, 16'hFF9C, 8'hF9);
    run_div("s_m5_0",     1'b1, 16'hFFFB, 8'd0);
`endif

    // Start held high: back-to-back operations every DW+2 cycles.
    base = done_cnt;
    done_times.delete();
    @(negedge clk);
    sgn = 1'b0; dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
    repeat (3) exp_q.push_back(model(1'b0, 16'd1000, 8'd7));
    n = 0;
    while (n < 200 && (done_cnt - base) < 3) begin
      @(negedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("b2b_count", 32'(done_cnt - base), 32'd3);
    if (done_times.size() >= 3) begin
      check("b2b_spacing1", 32'(done_times[1] - done_times[0]), 32'(PERIOD));
      check("b2b_spacing2", 32'(done_times[2] - done_times[1]), 32'(PERIOD));
    end
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("b2b_no_extra", 32'(done_cnt - base), 32'd3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
